pulse_timer_fsm: RTL

PULSE_TIMER_FSM -- requirements
Module: pulse_timer_fsm

---
 rtl/pulse_timer_pkg.sv | 20 ++
 rtl/pulse_timer_fsm_edge_rise_det.sv | 38 +++
 rtl/pulse_timer_fsm.sv | 135 +++++++++++++
 3 files changed

// File: rtl/pulse_timer_pkg.sv
// -----------------------------------------------------------------------------
// pulse_timer_pkg
// Shared definitions for the pulse timer: the FSM state encoding and the
// default values of the timer parameters.
//   state_e          : IDLE / ON / COOL, 2-bit encoding (2'b11 is unreachable)
//   CNT_W_DEFAULT    : default counter / Len width
//   DEF_LEN_DEFAULT  : default pulse length used when Len is 0
// -----------------------------------------------------------------------------
package pulse_timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ON   = 2'b01,
      COOL = 2'b10
   } state_e;

   localparam int CNT_W_DEFAULT   = 8;
   localparam int DEF_LEN_DEFAULT = 3;

endpackage : pulse_timer_pkg

// File: rtl/pulse_timer_fsm_edge_rise_det.sv
// -----------------------------------------------------------------------------
// edge_rise_det
// Rising-edge detector: registers the previous input level and flags a rise
// when the input is high while the registered copy is still low.
//   Clk  : clock, rising edge
//   Rst  : asynchronous active-low reset (clears the registered level)
//   In   : level input, synchronous to Clk
//   Rise : combinational, high while In==1 and the previous sampled In==0
// -----------------------------------------------------------------------------
module edge_rise_det (
   input  logic Clk,
   input  logic Rst,
   input  logic In,
   output logic Rise
);

   logic in_q;
   logic in_d;

   always_comb begin
      in_d = In;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values of its inputs, whatever the process order.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         in_q <= 1'b0;
      end else begin
         in_q <= in_d;
      end
   end

   // Clearing in_q on reset makes an input already high at the first edge
   // after reset count as a rise.
   assign Rise = In & ~in_q;

endmodule : edge_rise_det

// File: rtl/pulse_timer_fsm.sv
// -----------------------------------------------------------------------------
// pulse_timer_fsm
// Retriggerable-capable pulse timer. A rising edge on B starts a pulse on X
// lasting L cycles (L = Len, or DEF_LEN when Len is 0), followed by one COOL
// cycle that raises Done. Outputs are Moore outputs of the registered state.
//
// Parameters:
//   CNT_W   : width of the length counter and of Len
//   DEF_LEN : pulse length used when Len==0, legal range 1..2^CNT_W-1
// Ports:
//   Clk  : clock, all state updates on the rising edge
//   Rst  : asynchronous active-low reset
//   B    : trigger request (rising edge starts a pulse)
//   Len  : requested pulse length, sampled only at the trigger edge
//   X    : timed pulse output (high in ON)
//   Busy : high whenever the FSM is not in IDLE
//   Done : one-cycle completion strobe (high in COOL)
//
// Build option:
//   PULSE_TIMER_RETRIGGER_EN : when defined, a trigger during ON reloads the
//                              counter with the newly sampled length.
// -----------------------------------------------------------------------------
module pulse_timer_fsm
   import pulse_timer_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEFAULT,
   parameter int DEF_LEN = DEF_LEN_DEFAULT
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             B,
   input  logic [CNT_W-1:0] Len,
   output logic             X,
   output logic             Busy,
   output logic             Done
);

`ifdef PULSE_TIMER_RETRIGGER_EN
   localparam bit RETRIGGER_EN = 1'b1;
`else
   localparam bit RETRIGGER_EN = 1'b0;
`endif

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_e           state_q;
   state_e           state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] eff_len;
   logic             trig;

   edge_rise_det u_edge_rise_det (
      .Clk  (Clk),
      .Rst  (Rst),
      .In   (B),
      .Rise (trig)
   );

   // Len==0 is a request for the default length.
   assign eff_len = (Len == '0) ? CNT_W'(DEF_LEN) : Len;

   // State register
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic
   // NOTE: every signal written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (trig) begin
               state_d = ON;
               cnt_d   = eff_len;
            end
         end
         ON: begin
            // cnt holds the number of ON cycles still to go including this
            // one, so leaving at cnt==1 gives exactly L cycles. The <= also
            // covers a zero count, so the counter can never underflow.
            if (cnt_q <= CNT_ONE) begin
               state_d = COOL;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
            // A reload takes priority even over the final ON cycle.
            if (RETRIGGER_EN && trig) begin
               state_d = ON;
               cnt_d   = eff_len;
            end
         end
         COOL: begin
            // Triggers are dropped here; the edge detector still updates,
            // so a level held across this edge is never seen later.
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Output decode from registered state only
   always_comb begin
      X    = 1'b0;
      Busy = 1'b0;
      Done = 1'b0;
      case (state_q)
         IDLE: ;
         ON: begin
            X    = 1'b1;
            Busy = 1'b1;
         end
         COOL: begin
            Busy = 1'b1;
            Done = 1'b1;
         end
         default: Busy = 1'b1;
      endcase
   end

endmodule : pulse_timer_fsm
